// File: rtl/bram_host_port_pkg.sv
// Shared types and widths for the bram host-side byte port.
package bram_host_port_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OFF_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DUMP_ADDR,
      DUMP_WAIT,
      DUMP_OUT
   } state_t;

endpackage

// File: rtl/bram_host_port_ptr.sv
// Byte pointer that wraps to zero after NUM_BYTES-1; clear outranks inc.
module bram_port_ptr
   import bram_host_port_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 64,
   parameter int unsigned PTR_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [PTR_W-1:0] value,
   output logic             last
);

   assign last = (value == PTR_W'(NUM_BYTES - 1));

   // Pointer register: synchronous active-low reset, clear, then wrapping increment.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         value <= '0;
      end else if (inc) begin
         value <= last ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/bram_host_port.sv
// Host-side end of the local-memory byte interface: serialises a host byte
// stream into bram line writes and streams a full chunk back on request.
module bram_host_port
   import bram_host_port_pkg::*;
#(
   parameter int unsigned num_bits = 512,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic              dump_req,
   input  logic              flush,
   output logic              load_done,
   output logic              dump_done,
   output logic              busy,
   output logic [BYTE_W-1:0] bram_host_input,
   output logic [OFF_W-1:0]  bram_offset,
   output logic              bram_line_write,
   input  logic [BYTE_W-1:0] bram_to_host
);

   localparam int unsigned NUM_BYTES = num_bits / 8;
   localparam int unsigned PTR_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_next;
   logic               wr_last;
   logic               rd_last;
   logic               wr_hs;
   logic               rd_hs;
   logic               wr_clr;
   logic [WAIT_W-1:0]  wait_cnt;

   // flush and a pending dump both close the input so neither races a write.
   assign s_ready = !flush && (((state == IDLE) && !dump_req) || (state == LOAD));
   assign wr_hs   = s_valid && s_ready;
   assign wr_clr  = flush && ((state == IDLE) || (state == LOAD));
   assign rd_hs   = (state == DUMP_OUT) && m_valid && m_ready;
   assign rd_next = rd_ptr + 1'b1;

   bram_port_ptr #(
      .NUM_BYTES (NUM_BYTES),
      .PTR_W     (PTR_W)
   ) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .clear (wr_clr),
      .inc   (wr_hs),
      .value (wr_ptr),
      .last  (wr_last)
   );

   bram_port_ptr #(
      .NUM_BYTES (NUM_BYTES),
      .PTR_W     (PTR_W)
   ) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (rd_hs),
      .value (rd_ptr),
      .last  (rd_last)
   );

   // Control FSM; every output except s_ready is a flop, busy tracks the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         busy            <= 1'b0;
         load_done       <= 1'b0;
         dump_done       <= 1'b0;
         m_valid         <= 1'b0;
         m_data          <= '0;
         bram_line_write <= 1'b0;
         bram_host_input <= '0;
         bram_offset     <= '0;
         wait_cnt        <= '0;
      end else begin
         bram_line_write <= 1'b0;
         load_done       <= 1'b0;
         dump_done       <= 1'b0;
         unique case (state)
            IDLE, LOAD: begin
               if ((state == IDLE) && dump_req) begin
                  state       <= DUMP_ADDR;
                  busy        <= 1'b1;
                  bram_offset <= OFF_W'(rd_ptr);
               end else if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (wr_hs) begin
                  bram_line_write <= 1'b1;
                  bram_host_input <= s_data;
                  bram_offset     <= OFF_W'(wr_ptr);
                  load_done       <= wr_last;
                  state           <= wr_last ? IDLE : LOAD;
                  busy            <= !wr_last;
               end
            end
            DUMP_ADDR: begin
               state    <= DUMP_WAIT;
               wait_cnt <= '0;
            end
            DUMP_WAIT: begin
               if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
                  m_data  <= bram_to_host;
                  m_valid <= 1'b1;
                  state   <= DUMP_OUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DUMP_OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (rd_last) begin
                     dump_done <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end else begin
                     state       <= DUMP_ADDR;
                     bram_offset <= OFF_W'(rd_next);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bram_host_port.md
Name: bram_host_port

Overview:
- Host-side end of the local-memory byte interface.
- Takes a valid/ready byte stream from the host and serialises it into the bram line-write port (host_input / offset / line_read_from_host). One full chunk is num_bits/8 bytes.
- On request, sweeps every offset of the bram byte-read port (bram_to_host) and streams the bytes back to the host over a valid/ready output.
- Sits between the host link and bram; it is the writer/reader for the bram's host-facing side.

Parameters:
- num_bits, 512, chunk width in bits; must be a multiple of 8.
- NUM_BYTES, num_bits/8 (64), bytes per chunk; derived, not overridden.
- RD_LAT, 1, cycles from bram_offset being driven to bram_to_host being valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- s_data  in  8  host byte to write.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- m_data  out  8  readback byte to host.
- m_valid  out  1  m_data valid.
- m_ready  in  1  host accepts m_data.
- dump_req  in  1  start a full-chunk readback; level-sampled.
- flush  in  1  abandon a partial load and reset the write pointer.
- load_done  out  1  one-cycle pulse with the write strobe of byte NUM_BYTES-1.
- dump_done  out  1  one-cycle pulse on the final m_valid && m_ready handshake of a dump.
- busy  out  1  high in every state except IDLE.
- bram_host_input  out  8  to bram host_input.
- bram_offset  out  8  to bram offset.
- bram_line_write  out  1  to bram line_read_from_host; one-cycle write strobe.
- bram_to_host  in  8  byte read from bram at bram_offset.

Behaviour:
- Reset (rst==0 at a clock edge) applies regardless of state, including mid-load or mid-dump:
  - State goes to IDLE; wr_ptr and rd_ptr go to 0.
  - All outputs go to 0 except s_ready, which is 1 the cycle after reset releases.
- States are IDLE, LOAD, DUMP_ADDR, DUMP_WAIT and DUMP_OUT.
- s_ready is (IDLE && !dump_req) || LOAD. It is the only combinational output; everything else is registered.
- Write path (IDLE/LOAD):
  - On a handshake, the next cycle carries bram_line_write=1, bram_host_input=s_data and bram_offset=wr_ptr.
  - wr_ptr then increments. One byte per cycle is sustained.
  - The state is LOAD while wr_ptr!=0 after a write.
  - When the byte at wr_ptr==NUM_BYTES-1 is written, load_done pulses in the same cycle as its strobe, wr_ptr wraps to 0 and the state returns to IDLE.
- Flush:
  - flush in LOAD sets wr_ptr=0 and state=IDLE next cycle. Bytes already written stay in bram.
  - flush outranks a handshake in the same cycle: s_ready=0 while flush=1.
  - flush is ignored in the DUMP states.
- dump_req:
  - Honoured only in IDLE; it takes priority over an s_valid in the same cycle.
  - It is ignored in LOAD; the host must complete the load or flush first.
- Dump sequence:
  - IDLE->DUMP_ADDR: drive bram_offset=rd_ptr.
  - DUMP_WAIT holds for RD_LAT cycles, then the block captures bram_to_host into m_data, sets m_valid=1 and enters DUMP_OUT.
  - m_data stays stable while m_valid && !m_ready.
  - On the handshake: if rd_ptr==NUM_BYTES-1, pulse dump_done, drop m_valid, reset rd_ptr to 0 and return to IDLE. Otherwise increment rd_ptr and return to DUMP_ADDR.
  - Throughput is at most one byte per RD_LAT+2 cycles.
- bram_line_write is never asserted outside the cycle following a write handshake, and never in a DUMP state.
- Pointer width is $clog2(NUM_BYTES). bram_offset is zero-extended to 8 bits.

Decomposition:
- Shared package holds the state enum (IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT), the BYTE_W=8 constant and the OFF_W=8 constant.
- The test bench reuses the package.
- One sub-module is natural: bram_port_ptr, a wrap-at-NUM_BYTES counter with clear and inc inputs and a last output. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
1. Reset, then stream 64 bytes with value i at index i, s_valid held high. Required: 64 consecutive bram_line_write strobes with offset 0..63 and data 0..63, load_done on the 64th, and busy low one cycle later.
2. Load bytes 0xA5 and 0x5A alternating into a bram instance, then pulse dump_req with m_ready=1. Required: m_data sequence A5,5A,… (64 bytes), then dump_done on the last byte and busy=0 after.
3. During a dump, drop m_ready for 5 cycles on byte 10. Required: m_valid stays 1 and m_data is stable at the same value; no offset advance until the handshake.
4. Write 20 bytes, assert flush, then write 64 bytes of 0xFF. Required: first post-flush strobe at offset 0, with load_done on the 64th post-flush byte.
5. Assert s_valid and dump_req together in IDLE. Required: s_ready=0, no write strobe, and DUMP_ADDR entered next cycle.
6. Drive rst=0 for one cycle mid-dump (byte 30) and again mid-load (byte 12). Required: m_valid=0, load_done=0, bram_line_write=0 and busy=0 on the next cycle; the next load starts at offset 0.
